// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// Serialises one byte per request as an 8N1/8N2 UART frame:
//   start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1).
// Every bit lasts TICKS_PER_BIT cycles of baud_clk.
//
// Parameters
//   TICKS_PER_BIT : baud_clk cycles per serial bit (2..31)
//   STOP_BITS     : number of stop bits (1 or 2)
//
// Ports
//   baud_clk  in   oversampling tick clock, rising edge active
//   nrst      in   asynchronous, active-high reset
//   i_8_data  in   byte to send, sampled only when a request is accepted
//   i_send    in   level-sensitive transmit request, honoured in IDLE only
//   o_tx      out  serial line, registered, idles high
//   o_busy    out  high while a frame is in progress
//   o_done    out  one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int TICKS_PER_BIT = 16,
    parameter int STOP_BITS     = 1
) (
    input  logic       baud_clk,
    input  logic       nrst,
    input  logic [7:0] i_8_data,
    input  logic       i_send,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [4:0] TICK_LAST = 5'(TICKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t     state_q, state_d;
    logic [4:0] tick_q, tick_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic       tx_q, tx_d;
    logic       done_q, done_d;
    logic       tick_wrap;

    assign tick_wrap = (tick_q == TICK_LAST);

    always_ff @(posedge baud_clk or posedge nrst) begin
        if (nrst) begin
            state_q <= IDLE;
            tick_q  <= 5'd0;
            idx_q   <= 3'd0;
            hold_q  <= 8'h00;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                if (i_send) begin
                    state_d = START;
                    hold_d  = i_8_data;
                    tick_d  = 5'd0;
                    idx_d   = 3'd0;
                end
            end
            START: begin
                if (tick_wrap) begin
                    state_d = DATA;
                    tick_d  = 5'd0;
                    idx_d   = 3'd0;
                end else begin
                    tick_d = tick_q + 5'd1;
                end
            end
            DATA: begin
                if (tick_wrap) begin
                    tick_d = 5'd0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + 5'd1;
                end
            end
            STOP: begin
                // The bit index is reused to count stop bits, so the tick
                // counter never has to span more than one bit period.
                if (tick_wrap) begin
                    tick_d = 5'd0;
                    if (idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = 5'd0;
                idx_d   = 3'd0;
            end
        endcase

        // The line level is derived from the next state and registered, so
        // the start bit appears the cycle after acceptance and o_tx is
        // glitch-free with no path from the inputs.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = hold_d[idx_d];
            default: tx_d = 1'b1;
        endcase

        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    assign o_tx   = tx_q;
    assign o_busy = (state_q != IDLE);
    assign o_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//
// Self-checking bench for uart_transmitter. A default instance (16 ticks,
// 1 stop bit) is compared every cycle against a frame-level reference model;
// a second instance (4 ticks, 2 stop bits) is checked against a fixed
// expected waveform.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int T    = 16;
    localparam int FLEN = T * 10;

    logic       clk = 1'b0;
    logic       nrst;
    logic       send, send2;
    logic [7:0] data, data2;
    logic       tx, busy, done;
    logic       tx2, busy2, done2;

    always #5 clk = ~clk;

    uart_transmitter dut (
        .baud_clk (clk),
        .nrst     (nrst),
        .i_8_data (data),
        .i_send   (send),
        .o_tx     (tx),
        .o_busy   (busy),
        .o_done   (done)
    );

    uart_transmitter #(.TICKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .baud_clk (clk),
        .nrst     (nrst),
        .i_8_data (data2),
        .i_send   (send2),
        .o_tx     (tx2),
        .o_busy   (busy2),
        .o_done   (done2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level reference model: a frame is a position 0..FLEN-1 within
    // a sequence of ten bit periods (start, 8 data, stop).
    bit         m_busy;
    int         m_cyc;
    logic [7:0] m_data;
    bit         m_done;

    function automatic logic m_tx();
        int b;
        if (!m_busy) return 1'b1;
        b = m_cyc / T;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_data[b - 1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_cyc  = 0;
        m_data = 8'h00;
        m_done = 0;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model at the rising edge with the inputs that
    // were stable before it, then compare the DUT on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!nrst) begin
            if (!m_busy) begin
                m_done = 0;
                if (send) begin
                    m_busy = 1;
                    m_cyc  = 0;
                    m_data = data;
                end
            end else if (m_cyc == FLEN - 1) begin
                m_busy = 0;
                m_done = 1;
            end else begin
                m_cyc++;
                m_done = 0;
            end
        end
        @(negedge clk);
        check("tx", tx, m_tx());
        check("busy", busy, m_busy);
        check("done", done, m_done);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // transmitted bit k at index k
    } vec_t;

    vec_t vecs[5];

    initial begin
        int         busy_cnt;
        int         done_cnt;
        logic [10:0] f81;

        vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
        vecs[1] = '{8'h3C, 10'b1_0011_1100_0};
        vecs[2] = '{8'h00, 10'b1_0000_0000_0};
        vecs[3] = '{8'hFF, 10'b1_1111_1111_0};
        vecs[4] = '{8'h5A, 10'b1_0101_1010_0};

        // Reset state, observed before any clock edge.
        nrst  = 1'b1;
        send  = 1'b0;
        send2 = 1'b0;
        data  = 8'h00;
        data2 = 8'h00;
        model_reset();
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tx2", tx2, 1'b1);
        step();
        step();
        nrst = 1'b0;
        step();

        // Table-driven frames; data and extra requests are scrambled while
        // busy (including 8'hC3 with a request at cycle 40), none may matter.
        foreach (vecs[i]) begin
            data = vecs[i].data;
            send = 1'b1;
            step();
            send = 1'b0;
            busy_cnt = 0;
            for (int c = 0; c < FLEN; c++) begin
                if (c % T == T / 2) check("tbl_bit", tx, vecs[i].frame[c / T]);
                if (busy) busy_cnt++;
                if (c == 40) begin
                    data = 8'hC3;
                    send = 1'b1;
                end else if (c < FLEN - 10) begin
                    data = 8'($urandom);
                    send = ($urandom_range(0, 3) == 0);
                end else begin
                    send = 1'b0;
                end
                step();
            end
            check("tbl_done", done, 1'b1);
            check("tbl_idle", busy, 1'b0);
            check_int("tbl_busy_len", busy_cnt, FLEN);
            step();
            step();
        end

        // Back-to-back: 8'h00 then 8'hFF with i_send held high.
        data = 8'h00;
        send = 1'b1;
        step();
        for (int c = 0; c < FLEN; c++) step();
        check("b2b_gap_tx", tx, 1'b1);
        check("b2b_gap_done", done, 1'b1);
        data = 8'hFF;
        step();
        send = 1'b0;
        check("b2b_start", tx, 1'b0);
        for (int c = 0; c < FLEN; c++) begin
            if (c % T == T / 2 && c / T >= 1 && c / T <= 8) check("b2b_ff_bit", tx, 1'b1);
            step();
        end
        check("b2b_done2", done, 1'b1);
        step();

        // Reset at cycle 70 of a frame: immediate abort, no done pulse.
        data = 8'h3C;
        send = 1'b1;
        step();
        send = 1'b0;
        for (int c = 1; c < 70; c++) step();
        #2;
        nrst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        step();
        step();
        nrst = 1'b0;
        data = 8'h96;
        send = 1'b1;
        step();
        send = 1'b0;
        check("post_rst_start", tx, 1'b0);
        done_cnt = 0;
        for (int c = 0; c < FLEN + 4; c++) begin
            step();
            if (done) done_cnt++;
        end
        check_int("post_rst_done_cnt", done_cnt, 1);

        // 4 ticks per bit, 2 stop bits, byte 8'h81.
        f81   = 11'b11_1000_0001_0;
        data2 = 8'h81;
        send2 = 1'b1;
        step();
        send2 = 1'b0;
        busy_cnt = 0;
        for (int c = 1; c <= 48; c++) begin
            check("s2_tx", tx2, (c <= 44) ? f81[(c - 1) / 4] : 1'b1);
            check("s2_done", done2, c == 45);
            if (busy2) busy_cnt++;
            if (c < 48) step();
        end
        check_int("s2_busy_len", busy_cnt, 44);

        // Randomised traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            data = 8'($urandom);
            send = ($urandom_range(0, 9) == 0);
            step();
        end
        send = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter TICKS_PER_BIT, default 16, meaning baud_clk cycles per serial bit, legal range 2..31.
REQ-002 Parameter STOP_BITS, default 1, meaning number of stop bits, legal values 1 or 2.
REQ-003 baud_clk  input  1  clock: the oversampling tick clock; all state changes on its rising edge.
REQ-004 nrst  input  1  reset: asynchronous, active-high.
REQ-005 i_8_data  input  8  byte to transmit; sampled only at acceptance.
REQ-006 i_send  input  1  transmit request; level-sensitive.
REQ-007 o_tx  output  1  serial line; idle high.
REQ-008 o_busy  output  1  high while a frame is in progress.
REQ-009 o_done  output  1  one-cycle pulse on frame completion.

Function
REQ-010 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-011 Bit-timing tick counter: 5 bits; counts 0..TICKS_PER_BIT-1 in each bit period, then wraps to 0.
REQ-012 Bit index counter: 3 bits; selects the current data bit; counts 0..7.
REQ-013 Acceptance: in IDLE with i_send=1 at a rising edge, latch i_8_data into an internal shift/hold register, clear both counters, enter START.
REQ-014 i_send and i_8_data are ignored outside IDLE; changes to i_8_data after acceptance do not affect the frame in progress.
REQ-015 START: o_tx=0 for exactly TICKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-016 DATA: o_tx = latched bit[index], LSB first; each bit held TICKS_PER_BIT cycles.
REQ-017 DATA exit: after bit 7 completes, enter STOP.
REQ-018 STOP: o_tx=1 for TICKS_PER_BIT*STOP_BITS cycles, then enter IDLE.
REQ-019 o_tx SHALL be a registered output: no combinational path from i_send or i_8_data to o_tx; no glitches at bit boundaries.
REQ-020 o_tx timing: the first START-level cycle of o_tx appears in the cycle after acceptance.
REQ-021 o_busy=1 in START, DATA and STOP; 0 in IDLE.
REQ-022 o_done=1 for exactly one cycle, the first IDLE cycle after STOP; 0 otherwise.
REQ-023 Frame length: 1+8+STOP_BITS bit periods; with defaults, 160 cycles from first start cycle to last stop cycle.
REQ-024 Back-to-back: if i_send remains high, the next frame is accepted in the IDLE cycle in which o_done=1; o_tx holds 1 for exactly one cycle between frames.
REQ-025 Counter wrap: tick counter and bit index never exceed their terminal values; no state is reachable outside the four defined states.

Reset
REQ-026 On nrst=1, asynchronously and with no baud_clk edge required: state=IDLE, o_tx=1, o_busy=0, o_done=0, counters=0, hold register=8'h00.
REQ-027 Reset mid-frame: abort the frame immediately (o_tx returns high); no o_done pulse for the aborted frame.
REQ-028 After reset deasserts, the first rising edge with i_send=1 is accepted normally.

Verification
REQ-029 Single byte, defaults: i_8_data=8'hA5, i_send pulsed one cycle -> o_tx per 16-cycle bit: 0 (start), then data 1,0,1,0,0,1,0,1, then stop 1; o_busy high 160 cycles; o_done pulses once, at cycle 161 after acceptance.
REQ-030 i_send held high with 8'h00 then 8'hFF -> two contiguous frames separated by one idle-high cycle; second frame data bits all 1.
REQ-031 Change i_8_data from 8'h3C to 8'hC3 and pulse i_send at cycle 40 of an 8'h3C frame -> transmitted bits remain those of 8'h3C; the second request is ignored.
REQ-032 Assert nrst at cycle 70 of a frame -> o_tx=1 and o_busy=0 with no clock edge; o_done never pulses; the next request transmits a complete frame.
REQ-033 STOP_BITS=2, TICKS_PER_BIT=4, byte 8'h81 -> start lasts 4 cycles; data bits 1,0,0,0,0,0,0,1 at 4 cycles each; stop high for 8 cycles; o_busy high 44 cycles.
